// File: rtl/leg_hazard_ctrl_pkg.sv
// Shared types for the LEGv8 hazard controller: forwarding-select encodings
// and the shadow-pipeline slot layout.
package leg_hazard_ctrl_pkg;

  // Slot register fields are sized for the widest supported address (AW <= MAX_AW).
  localparam int MAX_AW = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef logic [MAX_AW-1:0] reg_id_t;

  typedef struct packed {
    logic    valid;
    logic    regwrite;
    logic    memread;
    reg_id_t rd;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/leg_hazard_ctrl_if.sv
// Bundle of ID-stage instruction fields, pipeline control inputs and the
// hazard/forwarding outputs of leg_hazard_ctrl.
interface leg_hazard_ctrl_if #(
  parameter int AW  = 5,
  parameter int NRD = 2,
  parameter int CW  = 16
);
  // id_valid qualifies all id_* fields; stall_if is the back-pressure, and while
  // it is high (or freeze is high) the ID side presents the same instruction again.
  logic              id_valid;
  logic [NRD*AW-1:0] id_rs;
  logic [NRD-1:0]    id_rs_used;
  logic [AW-1:0]     id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              ex_branch_taken;
  logic              mem_busy;
  logic              stall_if;
  logic              flush_ifid;
  logic              flush_idex;
  logic              freeze;
  logic [2*NRD-1:0]  fwd_sel;
  logic [CW-1:0]     stall_cnt;
  logic [CW-1:0]     flush_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread,
           ex_branch_taken, mem_busy,
    input  stall_if, flush_ifid, flush_idex, freeze, fwd_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread,
           ex_branch_taken, mem_busy,
    output stall_if, flush_ifid, flush_idex, freeze, fwd_sel, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/leg_fwd_cmp.sv
// Forwarding select for one EX source operand against the MEM and WB shadow slots.
module leg_fwd_cmp
  import leg_hazard_ctrl_pkg::*;
#(
  parameter int ZREG = 31
) (
  input  reg_id_t    rs_i,
  input  logic       rs_used_i,
  input  logic       ex_valid_i,
  input  slot_t      mem_i,
  input  slot_t      wb_i,
  output logic [1:0] sel_o
);

  // Load data only exists once the slot reaches WB, so a load in MEM is not a source.
  function automatic logic fwdable(slot_t s, logic data_ready, reg_id_t rs);
    return s.valid & s.regwrite & (~s.memread | data_ready) &
           (s.rd == rs) & (s.rd != reg_id_t'(ZREG));
  endfunction

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = ex_valid_i & rs_used_i & fwdable(mem_i, 1'b0, rs_i);
  assign wb_hit  = ex_valid_i & rs_used_i & fwdable(wb_i, 1'b1, rs_i);

  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/leg_hazard_ctrl.sv
// Load-use / branch-flush / memory-freeze controller for a 5-stage LEGv8 pipeline,
// tracking EX, MEM and WB in a shadow pipeline to drive the forwarding muxes.
module leg_hazard_ctrl
  import leg_hazard_ctrl_pkg::*;
#(
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int ZREG = 31,
  parameter int CW   = 16
) (
  input logic             clk,
  input logic             reset,
  leg_hazard_ctrl_if.slave bus
);

  slot_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [NRD*AW-1:0] ex_rs_q, ex_rs_d;
  logic [NRD-1:0]    ex_used_q, ex_used_d;
  logic [CW-1:0]     stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic rs_match, load_use, active, branch, stall;
  logic [2*NRD-1:0] fwd_sel;

  always_comb begin
    rs_match = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      if (bus.id_rs_used[k] && (reg_id_t'(bus.id_rs[k*AW +: AW]) == ex_q.rd)) begin
        rs_match = 1'b1;
      end
    end
  end

  assign load_use = bus.id_valid & ex_q.valid & ex_q.memread & ex_q.regwrite &
                    (ex_q.rd != reg_id_t'(ZREG)) & rs_match;

  // Freeze beats branch, branch beats load-use; reset silences everything but freeze.
  assign active = ~reset & ~bus.mem_busy;
  assign branch = active & bus.ex_branch_taken;
  assign stall  = active & ~bus.ex_branch_taken & load_use;

  assign bus.freeze     = bus.mem_busy;
  assign bus.stall_if   = stall;
  assign bus.flush_ifid = branch;
  assign bus.flush_idex = branch | stall;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.fwd_sel    = fwd_sel;

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    ex_rs_d     = ex_rs_q;
    ex_used_d   = ex_used_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.mem_busy) begin
      wb_d      = mem_q;
      mem_d     = ex_q;
      ex_rs_d   = bus.id_rs;
      ex_used_d = bus.id_rs_used;
      if (branch || stall) begin
        ex_d = SLOT_EMPTY;
      end else begin
        ex_d = '{valid: bus.id_valid, regwrite: bus.id_regwrite,
                 memread: bus.id_memread, rd: reg_id_t'(bus.id_rd)};
      end
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CW'(1);
      if (branch && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= SLOT_EMPTY;
      mem_q       <= SLOT_EMPTY;
      wb_q        <= SLOT_EMPTY;
      ex_rs_q     <= '0;
      ex_used_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      ex_rs_q     <= ex_rs_d;
      ex_used_q   <= ex_used_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_fwd
    leg_fwd_cmp #(.ZREG(ZREG)) u_cmp (
      .rs_i      (reg_id_t'(ex_rs_q[k*AW +: AW])),
      .rs_used_i (ex_used_q[k]),
      .ex_valid_i(ex_q.valid & ~reset),
      .mem_i     (mem_q),
      .wb_i      (wb_q),
      .sel_o     (fwd_sel[2*k +: 2])
    );
  end

endmodule

// File: tb/tb_leg_hazard_ctrl.sv
// Randomized bench for leg_hazard_ctrl against a queue-based model of in-flight
// instructions; narrow counters so saturation is reachable.
module tb_leg_hazard_ctrl;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int CW   = 6;
  localparam int ZREG = 31;
  localparam int SAT  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  leg_hazard_ctrl_if #(.AW(AW), .NRD(NRD), .CW(CW)) bus ();

  leg_hazard_ctrl #(.AW(AW), .NRD(NRD), .ZREG(ZREG), .CW(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit v;
    bit rw;
    bit mr;
    int rd;
    int rs[2];
    bit used[2];
  } rec_t;

  rec_t pipe[$];
  int   exp_stall_cnt, exp_flush_cnt;
  int   checks, failures;
  bit   last_hold;
  bit   cur_v, cur_u0, cur_u1, cur_rw, cur_mr;
  int   cur_rs0, cur_rs1, cur_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t empty_rec();
    rec_t r;
    r.v = 0; r.rw = 0; r.mr = 0; r.rd = 0;
    r.rs[0] = 0; r.rs[1] = 0; r.used[0] = 0; r.used[1] = 0;
    return r;
  endfunction

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(empty_rec());
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
  endtask

  // A producer supplies an operand if it writes that (non-zero) register and its
  // result exists at that stage: loads only in WB.
  function automatic bit supplies(rec_t p, int rs, bit in_wb);
    return p.v && p.rw && (p.rd == rs) && (p.rd != ZREG) && (!p.mr || in_wb);
  endfunction

  task automatic cycle(input bit rst, input bit v, input int rs0, input int rs1,
                       input bit u0, input bit u1, input int rd, input bit rw,
                       input bit mr, input bit br, input bit busy);
    rec_t ex, nw;
    bit lu, brk, stl;
    logic [3:0] efwd;
    int sel;
    @(negedge clk);
    reset               = rst;
    bus.id_valid        = v;
    bus.id_rs           = {AW'(rs1), AW'(rs0)};
    bus.id_rs_used      = {u1, u0};
    bus.id_rd           = AW'(rd);
    bus.id_regwrite     = rw;
    bus.id_memread      = mr;
    bus.ex_branch_taken = br;
    bus.mem_busy        = busy;
    #1;
    ex  = pipe[0];
    lu  = v && ex.v && ex.mr && ex.rw && (ex.rd != ZREG) &&
          ((u0 && rs0 == ex.rd) || (u1 && rs1 == ex.rd));
    brk = !rst && !busy && br;
    stl = !rst && !busy && !br && lu;
    efwd = '0;
    if (!rst && ex.v) begin
      for (int k = 0; k < NRD; k++) begin
        sel = 0;
        if (ex.used[k] && supplies(pipe[2], ex.rs[k], 1'b1)) sel = 1;
        if (ex.used[k] && supplies(pipe[1], ex.rs[k], 1'b0)) sel = 2;
        efwd[2*k +: 2] = 2'(sel);
      end
    end
    check_eq("freeze",     32'(bus.freeze),     32'(busy));
    check_eq("stall_if",   32'(bus.stall_if),   32'(stl));
    check_eq("flush_ifid", 32'(bus.flush_ifid), 32'(brk));
    check_eq("flush_idex", 32'(bus.flush_idex), 32'(brk || stl));
    check_eq("fwd_sel",    32'(bus.fwd_sel),    32'(efwd));
    check_eq("stall_cnt",  32'(bus.stall_cnt),  32'(exp_stall_cnt));
    check_eq("flush_cnt",  32'(bus.flush_cnt),  32'(exp_flush_cnt));
    last_hold = !rst && (stl || busy);
    if (rst) begin
      model_reset();
    end else if (!busy) begin
      nw = empty_rec();
      if (!(brk || stl)) begin
        nw.v = v; nw.rw = rw; nw.mr = mr; nw.rd = rd;
        nw.rs[0] = rs0; nw.rs[1] = rs1; nw.used[0] = u0; nw.used[1] = u1;
      end
      pipe.push_front(nw);
      void'(pipe.pop_back());
      if (stl && exp_stall_cnt < SAT) exp_stall_cnt++;
      if (brk && exp_flush_cnt < SAT) exp_flush_cnt++;
    end
  endtask

  task automatic bubbles(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rand_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? ZREG : r;
  endfunction

  task automatic rand_cycle(input int rst_odds);
    bit rst, br, busy;
    if (!last_hold) begin
      cur_v   = ($urandom_range(0, 7) != 0);
      cur_rs0 = rand_reg();
      cur_rs1 = rand_reg();
      cur_u0  = $urandom_range(0, 3) != 0;
      cur_u1  = $urandom_range(0, 1);
      cur_rd  = rand_reg();
      cur_mr  = ($urandom_range(0, 2) == 0);
      cur_rw  = cur_mr || ($urandom_range(0, 3) != 0);
    end
    rst  = ($urandom_range(0, rst_odds - 1) == 0);
    br   = ($urandom_range(0, 7) == 0);
    busy = ($urandom_range(0, 5) == 0);
    cycle(rst, cur_v, cur_rs0, cur_rs1, cur_u0, cur_u1, cur_rd, cur_rw, cur_mr, br, busy);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_hold = 0;
    reset = 1'b1;
    bus.id_valid = 0; bus.id_rs = '0; bus.id_rs_used = '0; bus.id_rd = '0;
    bus.id_regwrite = 0; bus.id_memread = 0; bus.ex_branch_taken = 0; bus.mem_busy = 0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset cycle with memory busy: only freeze may be high.
    cycle(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    bubbles(1);

    // LDUR X1 ; ADD X2,X1,X3 (stalled once, re-presented) ; ADD in EX gets WB forward.
    cycle(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    cycle(0, 1, 1, 3, 1, 1, 2, 1, 0, 0, 0);
    cycle(0, 1, 1, 3, 1, 1, 2, 1, 0, 0, 0);
    bubbles(4);

    // ADD X1 ; SUB X4,X1,X1 -> both operands from MEM.
    cycle(0, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 1, 1, 4, 1, 0, 0, 0);
    bubbles(3);

    // ADD X1 ; ADD X1 ; ADD X5,X1,X1 -> MEM wins over WB.
    cycle(0, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
    cycle(0, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 1, 1, 5, 1, 0, 0, 0);
    bubbles(3);

    // Load and ALU write to X31, then read X31: no stall, no forwarding.
    cycle(0, 1, 0, 0, 0, 0, ZREG, 1, 1, 0, 0);
    cycle(0, 1, ZREG, ZREG, 1, 1, ZREG, 1, 0, 0, 0);
    cycle(0, 1, ZREG, ZREG, 1, 1, 6, 1, 0, 0, 0);
    bubbles(3);

    // Branch taken while a load-use hazard is present: flush wins.
    cycle(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    cycle(0, 1, 1, 2, 1, 0, 2, 1, 0, 1, 0);
    bubbles(3);

    // Memory busy for three cycles over a load-use hazard, then one stall.
    cycle(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    repeat (3) cycle(0, 1, 1, 2, 1, 0, 2, 1, 0, 1, 1);
    cycle(0, 1, 1, 2, 1, 0, 2, 1, 0, 0, 0);
    cycle(0, 1, 1, 2, 1, 0, 2, 1, 0, 0, 0);
    bubbles(3);

    // Drive both counters past their saturation point.
    for (int i = 0; i < SAT + 10; i++) begin
      cycle(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      cycle(0, 1, 3, 3, 0, 1, 4, 1, 0, 0, 0);
      cycle(0, 1, 3, 3, 0, 1, 4, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    end
    bubbles(2);

    for (int i = 0; i < 4000; i++) rand_cycle(400);
    for (int i = 0; i < 1000; i++) rand_cycle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/leg_hazard_ctrl.md
LEG_HAZARD_CTRL -- requirements
Module: leg_hazard_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width.
REQ-002 SHALL have parameter NRD, default 2, source operands tracked per instruction (1..4).
REQ-003 SHALL have parameter ZREG, default 31, hardwired-zero register; never a forwarding or hazard source.
REQ-004 SHALL have parameter CW, default 16, width of saturating event counters.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 id_valid  in  1  IF/ID holds a real instruction.
REQ-008 id_rs  in  NRD*AW  source register numbers of ID instruction, operand k at bits [k*AW +: AW].
REQ-009 id_rs_used  in  NRD  operand k actually read.
REQ-010 id_rd, id_regwrite, id_memread  in  AW/1/1  destination, writes-register flag, is-load flag of ID instruction.
REQ-011 ex_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-012 mem_busy  in  1  data memory not ready; freeze whole pipeline.
REQ-013 stall_if  out  1  hold PC and IF/ID.
REQ-014 flush_ifid, flush_idex  out  1 each  load bubble into IF/ID, ID/EX.
REQ-015 freeze  out  1  equals mem_busy; hold every pipeline register.
REQ-016 fwd_sel  out  2*NRD  per EX operand: 00 register file, 01 WB result, 10 MEM result.
REQ-017 stall_cnt, flush_cnt  out  CW each  saturating counts of load-use stall and branch-flush cycles.

Function
REQ-018 SHALL keep a shadow pipeline of three slots EX, MEM, WB, each holding valid, rd, regwrite, memread, plus rs/rs_used for EX.
REQ-019 Normal cycle (no freeze, stall, flush): ID fields move into EX, EX->MEM, MEM->WB, WB discarded.
REQ-020 Load-use hazard SHALL be: id_valid, EX.valid, EX.memread, EX.regwrite, EX.rd != ZREG, and some used id_rs[k] == EX.rd.
REQ-021 On load-use hazard: stall_if=1, flush_idex=1, EX slot loaded invalid, EX->MEM->WB still advance; exactly one stall cycle per hazard.
REQ-022 On ex_branch_taken: flush_ifid=1, flush_idex=1, stall_if=0, EX slot loaded invalid; branch priority over load-use in the same cycle.
REQ-023 On mem_busy: freeze=1, shadow pipeline holds, stall_if/flush outputs 0, counters hold; mem_busy overrides branch and load-use.
REQ-024 fwd_sel SHALL be combinational from shadow slots: operand k selects 10 if MEM.valid & MEM.regwrite & MEM.rd==EX.rs[k] & MEM.rd!=ZREG & EX.rs_used[k]; else 01 under same test on WB; else 00. MEM has priority.
REQ-025 A load in MEM SHALL NOT produce 10 (data not yet available); load-use stall guarantees WB forwarding instead.
REQ-026 Invalid EX slot SHALL drive fwd_sel all 00.
REQ-027 stall_cnt increments on every cycle with load-use stall asserted; flush_cnt on every cycle with ex_branch_taken and no freeze; both saturate at all-ones, no wrap.
REQ-028 Outputs other than fwd_sel SHALL be combinational from inputs and shadow state; zero added latency.

Reset
REQ-029 While reset=1: all shadow slots invalid, counters 0, stall_if=0, flush_ifid=0, flush_idex=0, fwd_sel=0, freeze follows mem_busy.
REQ-030 Reset asserted mid-stall or mid-freeze SHALL abandon the event; first post-reset cycle behaves as empty pipeline.

Structure
REQ-031 Shared package SHALL hold fwd_sel encodings (FWD_RF, FWD_WB, FWD_MEM) and shadow-slot struct/field widths.
REQ-032 One sub-module leg_fwd_cmp (one operand vs MEM/WB slot -> 2-bit select), instantiated NRD times.

Verification
REQ-033 LDUR X1 then ADD X2,X1,X3 back-to-back -> one cycle stall_if=1, flush_idex=1, stall_cnt=1; ADD in EX sees fwd_sel op0=01.
REQ-034 ADD X1 then SUB X4,X1,X1 -> in EX both operands fwd_sel=10, no stall.
REQ-035 ADD X1; ADD X1; ADD X5,X1,X1 -> fwd_sel=10 (MEM wins over WB).
REQ-036 Writes to X31 followed by read of X31 -> no stall, fwd_sel=00.
REQ-037 ex_branch_taken with concurrent load-use hazard -> flush_ifid=1, flush_idex=1, stall_if=0, flush_cnt+1, stall_cnt unchanged.
REQ-038 mem_busy held 3 cycles during load-use hazard -> freeze=1 three cycles, shadow unchanged, then single stall cycle; counters saturate at 0xFFFF after 65535+ stall events.
